// File: rtl/motion_arbiter.sv
// motion_arbiter: shares the drive-motor command bus among spiral, wall-follow and
// bump-escape behaviours, forcing a stop settle window on each hand-over. Optional watchdog: MOTION_WDOG_EN.
module motion_arbiter #(
    parameter logic [31:0] SETTLE_CYCLES = 32'd8,
    parameter logic [31:0] MIN_HOLD      = 32'd200,
    parameter logic [31:0] WDOG_CYCLES   = 32'd100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] spd_in0,
    input  logic [2:0] spd_in1,
    input  logic [2:0] spd_in2,
    input  logic [9:0] cmd_in0,
    input  logic [9:0] cmd_in1,
    input  logic [9:0] cmd_in2,
    output logic [2:0] grant,
    output logic [1:0] owner,
    output logic [2:0] speed,
    output logic [9:0] command,
    output logic       busy,
    output logic       wdog_trip
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [2:0]  speed_q, speed_d;
    logic [9:0]  command_q, command_d;
    logic        busy_q, busy_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] settle_cnt_q, settle_cnt_d;

    logic [2:0]  mask;
    logic [2:0]  req_eff;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic        own_req;
    logic        preempt_esc;
    logic        preempt_wall;
    logic        wdog_hit;
    logic        exit_grant;
    logic        go_grant;

    function automatic logic [2:0] pick_spd(input logic [1:0] idx, input logic [2:0] s0,
                                            input logic [2:0] s1, input logic [2:0] s2);
        case (idx)
            2'd1:    return s1;
            2'd2:    return s2;
            default: return s0;
        endcase
    endfunction

    function automatic logic [9:0] pick_cmd(input logic [1:0] idx, input logic [9:0] c0,
                                            input logic [9:0] c1, input logic [9:0] c2);
        case (idx)
            2'd1:    return c1;
            2'd2:    return c2;
            default: return c0;
        endcase
    endfunction

    always_comb begin
        req_eff   = req & ~mask;
        win_valid = |req_eff;
        if (req_eff[2])      win_idx = 2'd2;
        else if (req_eff[1]) win_idx = 2'd1;
        else                 win_idx = 2'd0;
    end

    always_comb begin
        case (owner_q)
            2'd0:    own_req = req[0];
            2'd1:    own_req = req[1];
            2'd2:    own_req = req[2];
            default: own_req = 1'b0;
        endcase
        preempt_esc  = req_eff[2] && (owner_q != 2'd2);
        preempt_wall = (owner_q == 2'd0) && req_eff[1] && (hold_cnt_q >= MIN_HOLD);
        // All exit causes fold into one flag so coincident causes enter SETTLE once.
        exit_grant   = !own_req || preempt_esc || preempt_wall || wdog_hit;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = 3'b000;
        owner_d      = 2'b11;
        speed_d      = 3'd0;
        command_d    = 10'h000;
        busy_d       = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        settle_cnt_d = settle_cnt_q;
        go_grant     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_valid) go_grant = 1'b1;
            end
            S_GRANT: begin
                busy_d = 1'b1;
                if (exit_grant) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = 32'd0;
                end else begin
                    grant_d    = grant_q;
                    owner_d    = owner_q;
                    speed_d    = pick_spd(owner_q, spd_in0, spd_in1, spd_in2);
                    command_d  = pick_cmd(owner_q, cmd_in0, cmd_in1, cmd_in2);
                    hold_cnt_d = (hold_cnt_q == 32'hFFFF_FFFF) ? hold_cnt_q : hold_cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                busy_d = 1'b1;
                if (settle_cnt_q >= SETTLE_CYCLES - 32'd1) begin
                    if (win_valid) begin
                        go_grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_grant) begin
            state_d    = S_GRANT;
            grant_d    = 3'b001 << win_idx;
            owner_d    = win_idx;
            speed_d    = pick_spd(win_idx, spd_in0, spd_in1, spd_in2);
            command_d  = pick_cmd(win_idx, cmd_in0, cmd_in1, cmd_in2);
            busy_d     = 1'b1;
            hold_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 3'b000;
            owner_q      <= 2'b11;
            speed_q      <= 3'd0;
            command_q    <= 10'h000;
            busy_q       <= 1'b0;
            hold_cnt_q   <= 32'd0;
            settle_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            speed_q      <= speed_d;
            command_q    <= command_d;
            busy_q       <= busy_d;
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef MOTION_WDOG_EN
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic [2:0]  mask_q, mask_d;
    logic        wdog_trip_q, wdog_trip_d;

    assign mask     = mask_q;
    assign wdog_hit = (state_q == S_GRANT) && ((wdog_cnt_q + 32'd1) >= WDOG_CYCLES);

    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        // A mask bit survives only while its requester keeps asking.
        mask_d      = mask_q & req;
        wdog_trip_d = wdog_hit;
        if (go_grant)                wdog_cnt_d = 32'd0;
        else if (state_q == S_GRANT) wdog_cnt_d = wdog_cnt_q + 32'd1;
        if (wdog_hit) mask_d = mask_d | (3'b001 << owner_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt_q  <= 32'd0;
            mask_q      <= 3'b000;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            mask_q      <= mask_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    assign mask      = 3'b000;
    assign wdog_hit  = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign speed   = speed_q;
    assign command = command_q;
    assign busy    = busy_q;

endmodule
